// File: rtl/hdmi_pll_rst_seq.sv
// HDMI TX PLL power-up / lock supervisor: drives pll_reset, qualifies extlock, releases ser then pix resets.
// Optional PLL_SEQ_LOL_CNT_EN adds lol_cnt_o, a saturating count of loss-of-lock events seen in RUN.
module hdmi_pll_rst_seq #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned GAP_CYCLES    = 8,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       refclk_i,
    input  logic       reset_i,
    input  logic       restart_i,
    input  logic       extlock_i,
    output logic       pll_reset_o,
    output logic       rst_ser_o,
    output logic       rst_pix_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [1:0] retry_cnt_o
`ifdef PLL_SEQ_LOL_CNT_EN
    ,
    output logic [7:0] lol_cnt_o
`endif
);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_REL_SER   = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic             lk_meta_q, lk_s_q;
    logic             pll_reset_q, pll_reset_d;
    logic             rst_ser_q, rst_ser_d;
    logic             rst_pix_q, rst_pix_d;
    logic             locked_q, locked_d;
    logic             fail_q, fail_d;
    logic             attempt_fail;
    logic             lol_event;

    // State register, extlock synchroniser and registered outputs
    always_ff @(posedge refclk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_RESET;
            cnt_q       <= '0;
            retry_q     <= 2'd0;
            lk_meta_q   <= 1'b0;
            lk_s_q      <= 1'b0;
            pll_reset_q <= 1'b1;
            rst_ser_q   <= 1'b1;
            rst_pix_q   <= 1'b1;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lk_meta_q   <= extlock_i;
            lk_s_q      <= lk_meta_q;
            pll_reset_q <= pll_reset_d;
            rst_ser_q   <= rst_ser_d;
            rst_pix_q   <= rst_pix_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
        end
    end

    // Next-state logic; a single shared counter times every state
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        attempt_fail = 1'b0;
        lol_event    = 1'b0;
        if (restart_i) begin
            state_d = S_RESET;
            cnt_d   = '0;
            retry_d = 2'd0;
        end else begin
            case (state_q)
                S_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lk_s_q) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        attempt_fail = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_STABLE: begin
                    // A dropout returns to WAIT_LOCK without restarting the timeout window
                    if (!lk_s_q) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = cnt_q + CNT_ONE;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_REL_SER;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_REL_SER: begin
                    if (!lk_s_q) begin
                        attempt_fail = 1'b1;
                    end else if (cnt_q == GAP_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        retry_d = 2'd0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_RUN: begin
                    if (!lk_s_q) begin
                        attempt_fail = 1'b1;
                        lol_event    = 1'b1;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                end
            endcase

            if (attempt_fail) begin
                cnt_d   = '0;
                state_d = (retry_q == RETRY_LIMIT) ? S_FAIL : S_RESET;
                retry_d = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
            end
        end
    end

    // Outputs decoded from the next state so they change on the entry edge
    always_comb begin
        pll_reset_d = (state_d == S_RESET) || (state_d == S_FAIL);
        rst_ser_d   = (state_d != S_REL_SER) && (state_d != S_RUN);
        rst_pix_d   = (state_d != S_RUN);
        locked_d    = (state_d == S_RUN);
        fail_d      = (state_d == S_FAIL);
    end

    assign pll_reset_o = pll_reset_q;
    assign rst_ser_o   = rst_ser_q;
    assign rst_pix_o   = rst_pix_q;
    assign locked_o    = locked_q;
    assign fail_o      = fail_q;
    assign retry_cnt_o = retry_q;

`ifdef PLL_SEQ_LOL_CNT_EN
    logic [7:0] lol_cnt_q, lol_cnt_d;

    always_comb begin
        lol_cnt_d = lol_cnt_q;
        if (lol_event && (lol_cnt_q != 8'hFF)) begin
            lol_cnt_d = lol_cnt_q + 8'd1;
        end
    end

    // Only the hard reset clears this; restart keeps the history
    always_ff @(posedge refclk_i or posedge reset_i) begin
        if (reset_i) begin
            lol_cnt_q <= 8'd0;
        end else begin
            lol_cnt_q <= lol_cnt_d;
        end
    end

    assign lol_cnt_o = lol_cnt_q;
`else
    logic unused_lol;
    assign unused_lol = lol_event;
`endif

endmodule

// File: tb/tb_hdmi_pll_rst_seq.sv
// Bench for hdmi_pll_rst_seq: directed scenarios plus random extlock/restart traffic,
// checked every cycle against a timestamp-based reference model of the supervisor.
module tb_hdmi_pll_rst_seq;

    localparam int RSTC = 4;
    localparam int TMO  = 100;
    localparam int STC  = 8;
    localparam int GAP  = 3;
    localparam int MAXR = 2;

    localparam int M_RESET  = 0;
    localparam int M_WAIT   = 1;
    localparam int M_STABLE = 2;
    localparam int M_REL    = 3;
    localparam int M_RUN    = 4;
    localparam int M_FAIL   = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       extlock = 1'b0;
    logic       pll_reset, rst_ser, rst_pix, locked, fail;
    logic [1:0] retry_cnt;
`ifdef PLL_SEQ_LOL_CNT_EN
    logic [7:0] lol_cnt;
`endif

    always #5 clk = ~clk;

    hdmi_pll_rst_seq #(
        .RST_CYCLES   (RSTC),
        .LOCK_TIMEOUT (TMO),
        .STABLE_CYCLES(STC),
        .GAP_CYCLES   (GAP),
        .MAX_RETRY    (MAXR),
        .CNT_W        (16)
    ) dut (
        .refclk_i   (clk),
        .reset_i    (reset),
        .restart_i  (restart),
        .extlock_i  (extlock),
        .pll_reset_o(pll_reset),
        .rst_ser_o  (rst_ser),
        .rst_pix_o  (rst_pix),
        .locked_o   (locked),
        .fail_o     (fail),
        .retry_cnt_o(retry_cnt)
`ifdef PLL_SEQ_LOL_CNT_EN
        ,
        .lol_cnt_o  (lol_cnt)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: phase, cycle timestamp where the phase counter started, retries, LOL events
    int m_phase = M_RESET;
    int m_t0    = 0;
    int m_retry = 0;
    int m_lol   = 0;
    int cyc     = 0;
    bit ext_at [65536];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [6:0] dut_outs();
        return {pll_reset, rst_ser, rst_pix, locked, fail, retry_cnt};
    endfunction

    function automatic logic [6:0] model_outs();
        logic pll, ser, pix, lk, f;
        pll = (m_phase == M_RESET) || (m_phase == M_FAIL);
        ser = !((m_phase == M_REL) || (m_phase == M_RUN));
        pix = (m_phase != M_RUN);
        lk  = (m_phase == M_RUN);
        f   = (m_phase == M_FAIL);
        return {pll, ser, pix, lk, f, 2'(m_retry)};
    endfunction

    task automatic compare_all();
        check_eq("outs", 32'(dut_outs()), 32'(model_outs()));
`ifdef PLL_SEQ_LOL_CNT_EN
        check_eq("lol_cnt", 32'(lol_cnt), 32'(m_lol));
`endif
    endtask

    // Decision at the edge ending cycle c sees extlock as driven in cycle c-2
    task automatic model_step(input bit rs);
        int e;
        bit lks;
        bit afail;
        e     = cyc - m_t0;
        lks   = (cyc >= 2) ? ext_at[cyc-2] : 1'b0;
        afail = 1'b0;
        if (rs) begin
            m_phase = M_RESET;
            m_t0    = cyc + 1;
            m_retry = 0;
        end else begin
            case (m_phase)
                M_RESET:  if (e == RSTC - 1) begin m_phase = M_WAIT; m_t0 = cyc + 1; end
                M_WAIT:   if (lks) begin m_phase = M_STABLE; m_t0 = cyc + 1; end
                          else if (e == TMO - 1) afail = 1'b1;
                M_STABLE: if (!lks) m_phase = M_WAIT;
                          else if (e == STC - 1) begin m_phase = M_REL; m_t0 = cyc + 1; end
                M_REL:    if (!lks) afail = 1'b1;
                          else if (e == GAP - 1) begin m_phase = M_RUN; m_t0 = cyc + 1; m_retry = 0; end
                M_RUN:    if (!lks) begin afail = 1'b1; if (m_lol < 255) m_lol++; end
                default:  ;
            endcase
            if (afail) begin
                m_phase = (m_retry == MAXR) ? M_FAIL : M_RESET;
                m_retry = (m_retry >= 3) ? 3 : m_retry + 1;
                m_t0    = cyc + 1;
            end
        end
        cyc++;
    endtask

    task automatic tick(input bit ext, input bit rs);
        extlock = ext;
        restart = rs;
        if (cyc < 65536) ext_at[cyc] = ext;
        @(posedge clk);
        model_step(rs);
        #1;
        restart = 1'b0;
        compare_all();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        cyc     = 0;
        m_phase = M_RESET;
        m_t0    = 0;
        m_retry = 0;
        m_lol   = 0;
        compare_all();
    endtask

    // Tick with extlock high until the model reaches a phase (and counter value, or -1 for any)
    task automatic run_until(input int phase, input int cnt_val, input string tag);
        int  guard;
        bit  hit;
        hit = 1'b0;
        for (guard = 0; guard < 300; guard++) begin
            if (m_phase == phase && (cnt_val < 0 || (cyc - m_t0) == cnt_val)) begin
                hit = 1'b1;
                break;
            end
            tick(1'b1, 1'b0);
        end
        check_eq(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        int g;
        int k;
        bit healthy;
        bit e;

        // 1: power-up, extlock raised at cycle 10
        extlock = 1'b0;
        restart = 1'b0;
        reset   = 1'b1;
        release_reset();
        check_eq("reset_outs", 32'(dut_outs()), 32'(7'b1110000));
        repeat (3) tick(1'b0, 1'b0);
        check_eq("pll_c3", 32'(pll_reset), 32'd1);
        tick(1'b0, 1'b0);
        check_eq("pll_c4", 32'(pll_reset), 32'd0);
        repeat (6) tick(1'b0, 1'b0);
        repeat (10) tick(1'b1, 1'b0);
        check_eq("ser_c20", 32'(rst_ser), 32'd1);
        tick(1'b1, 1'b0);
        check_eq("ser_c21", 32'(rst_ser), 32'd0);
        check_eq("pix_c21", 32'(rst_pix), 32'd1);
        repeat (3) tick(1'b1, 1'b0);
        check_eq("pix_c24", 32'(rst_pix), 32'd0);
        check_eq("locked_c24", 32'(locked), 32'd1);

        // 2: no lock at all -> three timeouts then FAIL, held for 1000 cycles
        tick(1'b0, 1'b1);
        repeat (400) tick(1'b0, 1'b0);
        check_eq("fail_set", 32'(fail), 32'd1);
        check_eq("retry_sat", 32'(retry_cnt), 32'd3);
        repeat (1000) tick(1'b0, 1'b0);
        check_eq("fail_held", 32'(fail), 32'd1);
        check_eq("fail_pll", 32'(pll_reset), 32'd1);

        // 3: restart out of FAIL, then lock
        tick(1'b0, 1'b1);
        check_eq("restart_fail", 32'(fail), 32'd0);
        check_eq("restart_retry", 32'(retry_cnt), 32'd0);
        repeat (40) tick(1'b1, 1'b0);
        check_eq("relock", 32'(locked), 32'd1);

        // 4: one-cycle dropout inside STABLE
        tick(1'b0, 1'b1);
        repeat ($urandom_range(0, 20)) tick(1'b0, 1'b0);
        k = $urandom_range(0, 4);
        run_until(M_STABLE, k, "reach_stable");
        g = cyc;
        tick(1'b0, 1'b0);
        while (cyc < g + STC + 3) tick(1'b1, 1'b0);
        check_eq("glitch_ser_hold", 32'(rst_ser), 32'd1);
        tick(1'b1, 1'b0);
        check_eq("glitch_ser_rel", 32'(rst_ser), 32'd0);

        // 5: loss of lock in RUN
        run_until(M_RUN, -1, "reach_run");
        repeat ($urandom_range(1, 10)) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check_eq("lol_still_locked", 32'(locked), 32'd1);
        tick(1'b1, 1'b0);
        check_eq("lol_outs", 32'(dut_outs()), 32'(7'b1110001));
        repeat (40) tick(1'b1, 1'b0);
        check_eq("lol_relock", 32'(locked), 32'd1);
        check_eq("lol_retry_clr", 32'(retry_cnt), 32'd0);
`ifdef PLL_SEQ_LOL_CNT_EN
        check_eq("lol_cnt_one", 32'(lol_cnt), 32'd1);
`endif

        // 6: asynchronous reset in the middle of REL_SER
        tick(1'b0, 1'b1);
        run_until(M_REL, 1, "reach_rel");
        reset = 1'b1;
        #1;
        check_eq("async_rst", 32'(dut_outs()), 32'(7'b1110000));
        release_reset();

        // Random traffic: long healthy/unhealthy PLL spells, glitches, occasional restart
        healthy = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) healthy = !healthy;
            if (healthy) e = ($urandom_range(0, 299) != 0);
            else         e = ($urandom_range(0, 19) == 0);
            tick(e, $urandom_range(0, 399) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
